// File: rtl/delay_sender_pkg.sv
`default_nettype none
// ============================================================================
// Module   : delay_sender_pkg
// Brief    : Shared FSM state type and sizing helpers for delay_coef_sender.
// Revision : 1.0 - initial release
// ============================================================================
package delay_sender_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    SEND  = 2'd2
  } sender_state_t;

  function automatic int calc_depth(input int n_ch, input int n_dn);
    return n_ch * n_dn;
  endfunction

  // Keeps single-entry dimensions at a legal one-bit index width.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/delay_coef_ram.sv
`default_nettype none
// ============================================================================
// Module   : delay_coef_ram
// Brief    : Simple dual-port coefficient RAM, one write port and one
//            synchronous read port; contents are never reset.
// Revision : 1.0 - initial release
// ============================================================================
module delay_coef_ram #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 576,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
    rd_data <= r_mem[rd_addr];
  end

endmodule
`default_nettype wire

// File: rtl/delay_coef_sender.sv
`default_nettype none
// ============================================================================
// Module   : delay_coef_sender
// Brief    : Stores the fractional-delay coefficient table and streams it to
//            the Farrow coefficient port (channel fastest, then beam) on start.
//            Define DELAY_SENDER_DBUF_EN for active/shadow double buffering.
// Revision : 1.0 - initial release
// ============================================================================
module delay_coef_sender
  import delay_sender_pkg::*;
#(
  parameter  int WIGHT_DELAY = 18,
  parameter  int N_CHANALS   = 32,
  parameter  int N_DN        = 18,
  localparam int c_depth     = calc_depth(N_CHANALS, N_DN),
  localparam int c_aw        = clog2_min1(c_depth),
  localparam int c_cw        = clog2_min1(N_CHANALS),
  localparam int c_dw        = clog2_min1(N_DN)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [c_aw-1:0]        wr_addr,
  input  logic [WIGHT_DELAY-1:0] wr_data,
  output logic                   wr_err,
  input  logic                   start,
  output logic                   start_err,
  output logic                   busy,
  output logic                   vld_del,
  output logic                   last_del,
  output logic [WIGHT_DELAY-1:0] data_del,
  output logic [c_cw-1:0]        ch_idx,
  output logic [c_dw-1:0]        dn_idx
);

  localparam logic [c_aw-1:0] c_addr_last = c_aw'(c_depth - 1);
  localparam logic [c_cw-1:0] c_ch_last   = c_cw'(N_CHANALS - 1);

  sender_state_t          r_state;
  logic [c_aw-1:0]        r_rd_addr;
  logic                   r_rd_vld;
  logic                   r_rd_last;
  logic [WIGHT_DELAY-1:0] w_rd_data;
  logic                   w_idle;
  logic                   w_addr_ok;
  logic                   w_wr_ok;

  assign w_idle    = (r_state == IDLE);
  assign w_addr_ok = (32'(wr_addr) < c_depth);

`ifdef DELAY_SENDER_DBUF_EN
  logic                   r_bank_sel;
  logic [WIGHT_DELAY-1:0] w_bank_rd [2];

  assign w_wr_ok = wr_en && w_addr_ok;

  // Writes land in the bank not being streamed; start flips the roles.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    delay_coef_ram #(
      .WIDTH (WIGHT_DELAY),
      .DEPTH (c_depth),
      .AW    (c_aw)
    ) u_ram (
      .clk     (clk),
      .wr_en   (w_wr_ok && (r_bank_sel != 1'(b))),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (r_rd_addr),
      .rd_data (w_bank_rd[b])
    );
  end

  assign w_rd_data = w_bank_rd[r_bank_sel];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bank_sel <= 1'b0;
    end else if (start && w_idle) begin
      r_bank_sel <= ~r_bank_sel;
    end
  end
`else
  assign w_wr_ok = wr_en && w_addr_ok && w_idle;

  delay_coef_ram #(
    .WIDTH (WIGHT_DELAY),
    .DEPTH (c_depth),
    .AW    (c_aw)
  ) u_ram (
    .clk     (clk),
    .wr_en   (w_wr_ok),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (r_rd_addr),
    .rd_data (w_rd_data)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_rd_addr <= '0;
      r_rd_vld  <= 1'b0;
      r_rd_last <= 1'b0;
      busy      <= 1'b0;
      vld_del   <= 1'b0;
      last_del  <= 1'b0;
      data_del  <= '0;
      ch_idx    <= '0;
      dn_idx    <= '0;
      wr_err    <= 1'b0;
      start_err <= 1'b0;
    end else begin
      wr_err    <= wr_en && !w_wr_ok;
      start_err <= start && !w_idle;
      // r_rd_vld/r_rd_last describe the word now sitting on the RAM output.
      vld_del   <= r_rd_vld;
      last_del  <= r_rd_vld && r_rd_last;
      if (r_rd_vld) begin
        data_del <= w_rd_data;
        if (!vld_del) begin
          ch_idx <= '0;
          dn_idx <= '0;
        end else if (ch_idx == c_ch_last) begin
          ch_idx <= '0;
          dn_idx <= dn_idx + 1'b1;
        end else begin
          ch_idx <= ch_idx + 1'b1;
        end
      end

      case (r_state)
        IDLE: begin
          if (start) begin
            r_state   <= PRIME;
            busy      <= 1'b1;
            r_rd_addr <= '0;
          end
        end
        PRIME: begin
          r_rd_vld  <= 1'b1;
          r_rd_last <= (c_depth == 1);
          r_rd_addr <= r_rd_addr + 1'b1;
          r_state   <= SEND;
        end
        SEND: begin
          if (r_rd_last) begin
            r_rd_vld <= 1'b0;
          end else begin
            r_rd_last <= (r_rd_addr == c_addr_last);
            r_rd_addr <= r_rd_addr + 1'b1;
          end
          if (last_del) begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_delay_coef_sender.sv
`default_nettype none
// ============================================================================
// Module   : tb_delay_coef_sender
// Brief    : Directed scoreboard bench for delay_coef_sender (4 ch x 3 beams).
// Revision : 1.0 - initial release
// ============================================================================
module tb_delay_coef_sender;

  localparam int W     = 18;
  localparam int NC    = 4;
  localparam int ND    = 3;
  localparam int DEPTH = NC * ND;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [3:0]    wr_addr;
  logic [W-1:0]  wr_data;
  logic          wr_err;
  logic          start;
  logic          start_err;
  logic          busy;
  logic          vld_del;
  logic          last_del;
  logic [W-1:0]  data_del;
  logic [1:0]    ch_idx;
  logic [1:0]    dn_idx;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
    logic [1:0]   ch;
    logic [1:0]   dn;
  } exp_t;

  exp_t         q[$];
  logic [W-1:0] model [2][DEPTH];
  int           model_sel  = 0;
  int           total      = 0;
  int           bad        = 0;
  int           words_seen = 0;

  delay_coef_sender #(
    .WIGHT_DELAY (W),
    .N_CHANALS   (NC),
    .N_DN        (ND)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_err    (wr_err),
    .start     (start),
    .start_err (start_err),
    .busy      (busy),
    .vld_del   (vld_del),
    .last_del  (last_del),
    .data_del  (data_del),
    .ch_idx    (ch_idx),
    .dn_idx    (dn_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mon_step();
    exp_t e;
    if (!rst) begin
      if (vld_del) begin
        words_seen++;
        chk("word_expected", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("data_del", data_del, e.data);
          chk("last_del", last_del, e.last);
          chk("ch_idx", ch_idx, e.ch);
          chk("dn_idx", dn_idx, e.dn);
        end
      end else if (last_del) begin
        chk("last_without_vld", last_del, 0);
      end
    end
  endtask

  task automatic do_write(input int addr, input int val, input bit exp_err);
    int wb;
`ifdef DELAY_SENDER_DBUF_EN
    wb = 1 - model_sel;
`else
    wb = 0;
`endif
    wr_addr = 4'(addr);
    wr_data = W'(val);
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
    chk("wr_err", wr_err, 32'(exp_err));
    if (!exp_err) model[wb][addr] = W'(val);
    tick();
    chk("wr_err_pulse", wr_err, 0);
  endtask

  task automatic load_table();
    for (int i = 0; i < DEPTH; i++) do_write(i, 100 + i, 1'b0);
  endtask

  task automatic do_start(input bit exp_acc);
    exp_t e;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_err", start_err, 32'(!exp_acc));
    if (exp_acc) begin
      chk("busy_on", busy, 1);
`ifdef DELAY_SENDER_DBUF_EN
      model_sel = 1 - model_sel;
`endif
      for (int i = 0; i < DEPTH; i++) begin
        e.data = model[model_sel][i];
        e.last = (i == DEPTH - 1);
        e.ch   = 2'(i % NC);
        e.dn   = 2'(i / NC);
        q.push_back(e);
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    chk("idle_timeout", busy, 0);
    chk("queue_drained", q.size(), 0);
  endtask

  task automatic wait_words(input int n);
    int base = words_seen;
    int c    = 0;
    while (words_seen < base + n && c < 200) begin
      tick();
      c++;
    end
    chk("words_timeout", 32'(words_seen >= base + n), 1);
  endtask

  task automatic wait_last();
    int c = 0;
    while (last_del !== 1'b1 && c < 200) begin
      tick();
      c++;
    end
    chk("last_timeout", last_del, 1);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
    fork
      forever begin
        @(negedge clk);
        mon_step();
      end
    join_none

    tick(); tick(); tick();
    chk("rst_vld", vld_del, 0);
    chk("rst_last", last_del, 0);
    chk("rst_data", data_del, 0);
    chk("rst_ch", ch_idx, 0);
    chk("rst_dn", dn_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_err", wr_err, 0);
    chk("rst_start_err", start_err, 0);
    rst = 1'b0;
    tick();

    load_table();
`ifdef DELAY_SENDER_DBUF_EN
    do_start(1'b1);
    wait_idle();
    load_table();
`endif

    // Basic burst with first-word latency
    do_start(1'b1);
    chk("vld_k", vld_del, 0);
    tick();
    chk("vld_k1", vld_del, 0);
    tick();
    chk("vld_k2", vld_del, 1);
    wait_idle();

    // Start while busy, then start on the last_del cycle, then right after
    do_start(1'b1);
    wait_words(5);
    do_start(1'b0);
    wait_idle();
    do_start(1'b1);
    wait_last();
    do_start(1'b0);
    chk("busy_fell", busy, 0);
    do_start(1'b1);
    wait_idle();

    // Write during a burst
    do_start(1'b1);
    wait_words(3);
`ifdef DELAY_SENDER_DBUF_EN
    do_write(0, 999, 1'b0);
`else
    do_write(0, 999, 1'b1);
`endif
    wait_idle();
    do_start(1'b1);
    wait_idle();

    // Reset mid-burst
    do_start(1'b1);
    wait_words(7);
    rst = 1'b1;
    #1;
    chk("rst_mid_vld", vld_del, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_last", last_del, 0);
    q.delete();
    model_sel = 0;
    tick();
    rst = 1'b0;
    tick();
    do_start(1'b1);
    wait_idle();

    // Out-of-range write leaves the table untouched
    do_write(12, 555, 1'b1);
    do_start(1'b1);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/delay_coef_sender.md
# delay_coef_sender

Streams the fractional-delay coefficient table to the Farrow beamformer's coefficient port in the order it consumes it: channel index fastest, then beam (DN) index. The table is first written into local RAM through a simple write port. A start pulse then emits N_CHANALS×N_DN words as a gap-free vld_del/last_del/data_del burst. The block sits on the coefficient clock domain, driving the Farrow block's clk_del-side inputs directly.

## Interface
- wight_delay, 18, coefficient word width
- N_chanals, 32, channels per beam
- N_DN, 18, number of beams (DN)
- clk  in  1  coefficient clock; the Farrow block's clk_del is connected to this net
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  table write strobe
- wr_addr  in  $clog2(N_chanals*N_DN)  write address = dn*N_chanals + ch
- wr_data  in  wight_delay  coefficient to store
- wr_err  out  1  one-cycle pulse: write dropped
- start  in  1  one-cycle request to send the table
- start_err  out  1  one-cycle pulse: start ignored (busy)
- busy  out  1  high from accepted start until the cycle after last_del
- vld_del  out  1  coefficient valid
- last_del  out  1  final word of table
- data_del  out  wight_delay  coefficient
- ch_idx  out  $clog2(N_chanals)  channel index of current data_del
- dn_idx  out  $clog2(N_DN)  beam index of current data_del

## Operation
- Storage is a RAM of DEPTH = N_chanals*N_DN words with synchronous read. It is not reset; contents survive rst.
- FSM states:
  - IDLE: start → PRIME, busy=1.
  - PRIME: read addr 0 issued → SEND.
  - SEND: the read address increments every cycle; one word is output per cycle. After the output of address DEPTH-1 → IDLE.
- Output order: addr 0..DEPTH-1, so ch_idx counts 0..N_chanals-1 and wraps, incrementing dn_idx. dn_idx wraps at N_DN-1 only on the final word.
- last_del=1 only together with vld_del on addr DEPTH-1.
- start while busy: ignored, start_err pulses the following cycle, and the burst continues unaffected.
- start in the same cycle the burst ends (last_del high): ignored with start_err. A new start is accepted from the next cycle.
- Write while busy (macro off): dropped, wr_err pulses next cycle. Write while idle: stored.
- wr_addr ≥ DEPTH: dropped, wr_err pulses.
- Write and start in the same idle cycle: the write completes first and is included in the burst.
- No backpressure: the receiver always accepts.

## Timing
- Reset values: vld_del=0, last_del=0, data_del=0, ch_idx=0, dn_idx=0, busy=0, wr_err=0, start_err=0, FSM=IDLE.
- All outputs are registered.
- Start sampled at edge k → busy high after k. First vld_del high after edge k+2.
- vld_del stays high for exactly DEPTH consecutive cycles. last_del is on the DEPTH-th of them. busy falls after the edge that drops vld_del.
- rst asserted mid-burst: all outputs go to 0 asynchronously; no last_del is emitted. The next start restarts at addr 0.

## Configuration
- DELAY_SENDER_DBUF_EN defined:
  - Two RAM banks (active/shadow); writes always go to the shadow bank and wr_err never fires for busy.
  - An accepted start swaps the banks and then sends the new active bank, so the table can be rewritten during a burst.
  - Out-of-range writes still give wr_err.
- DELAY_SENDER_DBUF_EN undefined: single bank, with the busy-write drop rule above.

## Structure
- delay_sender_pkg:
  - FSM state enum typedef (IDLE, PRIME, SEND)
  - Function returning DEPTH
  - Address-width localparam helper via $clog2
- Sub-module delay_coef_ram:
  - Simple dual-port RAM: one write port, one synchronous-read port.
  - Instantiated twice when DELAY_SENDER_DBUF_EN is defined.

## Test plan
- N_chanals=4, N_DN=3: write addr i with value 100+i, then start → 12 consecutive vld_del carrying 100..111. last_del only on 111. ch_idx sequence 0,1,2,3 repeated; dn_idx 0,0,0,0,1,1,1,1,2,2,2,2. First vld_del 2 cycles after start.
- Start pulsed again at word 5 of a burst → start_err pulse, burst still exactly 12 words. Start in the cycle after busy falls → accepted.
- Macro off, wr_en at word 3 of a burst to addr 0 with 999 → wr_err pulse; a second burst still sends 100 at addr 0.
- Macro on, same write during the burst → no wr_err, current burst sends 100. The next start's burst sends 999 first.
- rst asserted at word 7 → vld_del/busy drop immediately, no last_del. After release, start → full 12-word burst, RAM data intact.
- wr_addr=12 → wr_err pulse, no RAM change.
